// File: rtl/ic_miss_ctrl_pkg.sv
// Shared IC miss-path constants, entry state encoding and fill-beat record.
package ic_miss_ctrl_pkg;

  localparam int NMSHR   = 4;
  localparam int ID_W    = 2;
  localparam int LADDR_W = 34;
  localparam int BEATS   = 4;
  localparam int BEAT_W  = 128;
  localparam int BIDX_W  = 2;

  typedef enum logic [1:0] {
    ENT_FREE = 2'd0,
    ENT_REQ  = 2'd1,
    ENT_WAIT = 2'd2
  } ent_state_e;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [LADDR_W-1:0] laddr;
    logic [BIDX_W-1:0]  beat;
    logic [BEAT_W-1:0]  data;
    logic               last;
  } fill_t;

  function automatic logic is_last_beat(input logic [BIDX_W-1:0] beat);
    return beat == BIDX_W'(BEATS - 1);
  endfunction

endpackage

// File: rtl/ic_rr_arb.sv
// Round-robin arbiter with a registered, locked grant; evaluates next-cycle requests
// so a request raised at a clock edge is granted at that same edge.
module ic_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_nxt_i,
  input  logic          accept_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic          gnt_valid_q;
  logic [IW-1:0] gnt_idx_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_base;
  logic [IW-1:0] idx;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          reload;

  assign reload = !gnt_valid_q || accept_i;

  always_comb begin
    ptr_base   = accept_i ? gnt_idx_q + 1'b1 : ptr_q;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = '0;
    // Walk from farthest to nearest so the nearest request to the pointer wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr_base + IW'(k);
      if (req_nxt_i[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      if (accept_i) ptr_q <= gnt_idx_q + 1'b1;
      if (reload) begin
        gnt_valid_q <= pick_valid;
        gnt_idx_q   <= pick_idx;
      end
    end
  end

  assign gnt_valid_o = gnt_valid_q;
  assign gnt_idx_o   = gnt_idx_q;

endmodule

// File: rtl/ic_miss_ctrl.sv
// Instruction-cache miss-status controller: merges duplicate line misses, issues one L2
// request per line and streams L2 fill beats into the data array through a 1-deep register.
module ic_miss_ctrl
  import ic_miss_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_valid,
  output logic               miss_retry,
  input  logic [LADDR_W-1:0] miss_laddr,
  output logic               l2req_valid,
  input  logic               l2req_retry,
  output logic [LADDR_W-1:0] l2req_laddr,
  output logic [ID_W-1:0]    l2req_id,
  input  logic               snack_valid,
  output logic               snack_retry,
  input  logic [ID_W-1:0]    snack_id,
  input  logic [BIDX_W-1:0]  snack_beat,
  input  logic [BEAT_W-1:0]  snack_data,
  output logic               fill_valid,
  input  logic               fill_retry,
  output logic [LADDR_W-1:0] fill_laddr,
  output logic [BIDX_W-1:0]  fill_beat,
  output logic [BEAT_W-1:0]  fill_data,
  output logic               fill_last,
  output logic               busy
);

  ent_state_e         state_q [NMSHR];
  ent_state_e         state_d [NMSHR];
  logic [LADDR_W-1:0] laddr_q [NMSHR];
  logic [BIDX_W-1:0]  beat_q  [NMSHR];

  logic               fill_valid_q;
  fill_t              fill_q;

  logic [NMSHR-1:0]   is_free;
  logic [NMSHR-1:0]   match;
  logic [NMSHR-1:0]   req_nxt;
  logic               hit, any_free, alloc;
  logic [ID_W-1:0]    alloc_idx;
  logic               free_now;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_idx;
  logic               l2_acc;
  logic               snack_acc, snack_ok, snack_take;

  // An entry releasing its last beat this cycle must not absorb a new miss.
  assign free_now = fill_valid_q && fill_q.last && !fill_retry;

  genvar gi;
  generate
    for (gi = 0; gi < NMSHR; gi++) begin : gen_ent
      assign is_free[gi] = (state_q[gi] == ENT_FREE);
      assign match[gi]   = !is_free[gi] && (laddr_q[gi] == miss_laddr) &&
                           !(free_now && fill_q.id == ID_W'(gi));
      assign req_nxt[gi] = (state_d[gi] == ENT_REQ);
    end
  endgenerate

  assign hit      = |match;
  assign any_free = |is_free;

  always_comb begin
    alloc_idx = '0;
    for (int i = NMSHR - 1; i >= 0; i--) begin
      if (is_free[i]) alloc_idx = ID_W'(i);
    end
  end

  assign alloc       = miss_valid && !hit && any_free;
  assign miss_retry  = miss_valid && !hit && !any_free;
  assign l2_acc      = gnt_valid && !l2req_retry;
  assign snack_retry = fill_valid_q && fill_retry;
  assign snack_acc   = snack_valid && !snack_retry;
  assign snack_ok    = (state_q[snack_id] == ENT_WAIT) && (snack_beat == beat_q[snack_id]);
  assign snack_take  = snack_acc && snack_ok;

  always_comb begin
    for (int i = 0; i < NMSHR; i++) begin
      state_d[i] = state_q[i];
      if (free_now && fill_q.id == ID_W'(i))  state_d[i] = ENT_FREE;
      if (alloc && alloc_idx == ID_W'(i))     state_d[i] = ENT_REQ;
      if (l2_acc && gnt_idx == ID_W'(i))      state_d[i] = ENT_WAIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NMSHR; i++) begin
        state_q[i] <= ENT_FREE;
        laddr_q[i] <= '0;
        beat_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NMSHR; i++) begin
        state_q[i] <= state_d[i];
        if (alloc && alloc_idx == ID_W'(i)) begin
          laddr_q[i] <= miss_laddr;
          beat_q[i]  <= '0;
        end else if (snack_take && snack_id == ID_W'(i)) begin
          beat_q[i] <= beat_q[i] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_valid_q <= 1'b0;
      fill_q       <= '0;
    end else if (snack_take) begin
      fill_valid_q <= 1'b1;
      fill_q.id    <= snack_id;
      fill_q.laddr <= laddr_q[snack_id];
      fill_q.beat  <= snack_beat;
      fill_q.data  <= snack_data;
      fill_q.last  <= is_last_beat(snack_beat);
    end else if (!fill_retry) begin
      fill_valid_q <= 1'b0;
    end
  end

  ic_rr_arb #(.N(NMSHR), .IW(ID_W)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_nxt_i   (req_nxt),
    .accept_i    (l2_acc),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign l2req_valid = gnt_valid;
  assign l2req_laddr = laddr_q[gnt_idx];
  assign l2req_id    = gnt_idx;
  assign fill_valid  = fill_valid_q;
  assign fill_laddr  = fill_q.laddr;
  assign fill_beat   = fill_q.beat;
  assign fill_data   = fill_q.data;
  assign fill_last   = fill_q.last;
  assign busy        = ~&is_free;

  a_snack_legal: assert property (@(posedge clk) disable iff (reset) snack_acc |-> snack_ok);

endmodule

// File: tb/tb_ic_miss_ctrl.sv
// Scoreboard bench for ic_miss_ctrl: directed scenarios plus randomized traffic against a line-level model.
module tb_ic_miss_ctrl;

  logic         clk = 0;
  logic         reset;
  logic         miss_valid, miss_retry;
  logic [33:0]  miss_laddr;
  logic         l2req_valid, l2req_retry;
  logic [33:0]  l2req_laddr;
  logic [1:0]   l2req_id;
  logic         snack_valid, snack_retry;
  logic [1:0]   snack_id, snack_beat;
  logic [127:0] snack_data;
  logic         fill_valid, fill_retry;
  logic [33:0]  fill_laddr;
  logic [1:0]   fill_beat;
  logic [127:0] fill_data;
  logic         fill_last, busy;

  ic_miss_ctrl dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_retry(miss_retry), .miss_laddr(miss_laddr),
    .l2req_valid(l2req_valid), .l2req_retry(l2req_retry), .l2req_laddr(l2req_laddr), .l2req_id(l2req_id),
    .snack_valid(snack_valid), .snack_retry(snack_retry), .snack_id(snack_id),
    .snack_beat(snack_beat), .snack_data(snack_data),
    .fill_valid(fill_valid), .fill_retry(fill_retry), .fill_laddr(fill_laddr),
    .fill_beat(fill_beat), .fill_data(fill_data), .fill_last(fill_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [33:0]  laddr;
    logic [1:0]   beat;
    logic [127:0] data;
    logic         last;
  } fexp_t;

  // Line-level model: 0 = idle slot, 1 = awaiting L2 request, 2 = awaiting fill.
  int          m_state [4];
  logic [33:0] m_laddr [4];
  fexp_t       fq[$];
  int          rq[$];
  int          grant_log[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        prev_l2_stall = 0;
  logic [1:0]  prev_l2_id = 0;
  logic        miss_retry_seen = 0;
  logic        hold_snack = 0;
  logic [33:0] pool [6] = '{34'h100, 34'h200, 34'h300, 34'h3_0000_0040, 34'h2_aaaa_5555, 34'h1_2345_6789};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_state[i] = 0;
      fq.delete(); rq.delete();
      prev_l2_stall = 0;
      miss_retry_seen = 0;
    end else begin
      int  free_id, alloc_id, l2acc_id, first_free;
      logic exp_busy, exp_req, exp_fv, exp_sr, exp_mr, hit;
      fexp_t e;
      free_id = -1; alloc_id = -1; l2acc_id = -1;
      exp_busy = 0; exp_req = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_state[i] != 0) exp_busy = 1;
        if (m_state[i] == 1) exp_req = 1;
      end
      chk("busy", busy, exp_busy);
      chk("l2req_valid", l2req_valid, exp_req);
      if (l2req_valid) begin
        chk("l2req_id_pending", m_state[l2req_id] == 1, 1);
        chk("l2req_laddr", l2req_laddr, m_laddr[l2req_id]);
      end
      if (prev_l2_stall) chk("l2req_id_hold", l2req_id, prev_l2_id);

      exp_fv = (fq.size() != 0);
      exp_sr = exp_fv && fill_retry;
      chk("fill_valid", fill_valid, exp_fv);
      chk("snack_retry", snack_retry, exp_sr);
      if (exp_fv && !fill_retry) begin
        e = fq.pop_front();
        chk("fill_laddr", fill_laddr, e.laddr);
        chk("fill_beat", fill_beat, e.beat);
        chk("fill_data", fill_data, e.data);
        chk("fill_last", fill_last, e.last);
        if (e.last) free_id = e.id;
      end

      if (miss_valid) begin
        hit = 0; first_free = -1;
        for (int i = 0; i < 4; i++) begin
          if (m_state[i] != 0 && i != free_id && m_laddr[i] == miss_laddr) hit = 1;
          if (m_state[i] == 0 && first_free < 0) first_free = i;
        end
        exp_mr = !hit && first_free < 0;
        chk("miss_retry", miss_retry, exp_mr);
        if (!hit && !exp_mr) alloc_id = first_free;
      end else begin
        chk("miss_retry_idle", miss_retry, 0);
      end
      miss_retry_seen = miss_retry;

      if (l2req_valid && !l2req_retry && m_state[l2req_id] == 1) begin
        l2acc_id = int'(l2req_id);
        rq.push_back(l2acc_id);
        grant_log.push_back(l2acc_id);
      end
      prev_l2_stall = l2req_valid && l2req_retry;
      prev_l2_id = l2req_id;

      if (snack_valid && !exp_sr) begin
        e.id = int'(snack_id); e.laddr = m_laddr[snack_id];
        e.beat = snack_beat; e.data = snack_data; e.last = (snack_beat == 2'd3);
        fq.push_back(e);
      end

      if (free_id >= 0) m_state[free_id] = 0;
      if (alloc_id >= 0) begin m_state[alloc_id] = 1; m_laddr[alloc_id] = miss_laddr; end
      if (l2acc_id >= 0) m_state[l2acc_id] = 2;
    end
  end

  // L2 responder: returns four in-order beats per accepted request, honouring snack_retry.
  initial begin
    int cur, b;
    logic acc;
    snack_valid = 0; snack_id = 0; snack_beat = 0; snack_data = 0;
    forever begin
      @(posedge clk); #1;
      snack_valid = 0;
      if (reset || hold_snack || rq.size() == 0 || $urandom_range(0, 2) == 0) continue;
      cur = rq.pop_front(); b = 0;
      snack_id = 2'(cur);
      snack_data = rnd128();
      while (b < 4 && !reset) begin
        snack_valid = 1; snack_beat = 2'(b);
        @(negedge clk);
        acc = !snack_retry && !reset;
        @(posedge clk); #1;
        if (acc) begin
          b++;
          snack_data = rnd128();
          if (b < 4 && $urandom_range(0, 3) == 0) begin
            snack_valid = 0;
            @(posedge clk); #1;
          end
        end
      end
      snack_valid = 0;
    end
  end

  task automatic wait_idle(input bit toggle);
    int n = 0;
    while ((busy !== 1'b0 || fq.size() != 0 || rq.size() != 0 || snack_valid) && n < 3000) begin
      step();
      if (toggle) fill_retry = ~fill_retry;
      n++;
    end
    fill_retry = 0;
    chk("idle_timeout", n < 3000, 1);
  endtask

  task automatic issue_miss(input logic [33:0] a);
    step(); miss_valid = 1; miss_laddr = a;
  endtask

  initial begin
    reset = 1; miss_valid = 0; miss_laddr = 0; l2req_retry = 0; fill_retry = 0;
    repeat (2) @(negedge clk);
    chk("rst_l2req_valid", l2req_valid, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miss_retry", miss_retry, 0);
    chk("rst_snack_retry", snack_retry, 0);
    step(); reset = 0;

    // Single line miss: request one cycle after allocation.
    issue_miss(34'h100);
    step(); miss_valid = 0;
    chk("t1_l2req_valid", l2req_valid, 1);
    chk("t1_l2req_laddr", l2req_laddr, 34'h100);
    chk("t1_l2req_id", l2req_id, 0);
    wait_idle(0);

    // Three entries held in REQ, then released: grant order follows the pointer.
    l2req_retry = 1;
    issue_miss(34'h100); issue_miss(34'h200); issue_miss(34'h300);
    step(); miss_valid = 0;
    repeat (3) step();
    grant_log.delete();
    l2req_retry = 0;
    wait_idle(0);
    chk("t4_grant_count", grant_log.size(), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++) chk("t4_grant_order", grant_log[i], i);

    // Duplicate miss merges; fill_retry toggles during the fills.
    grant_log.delete();
    issue_miss(34'h100); issue_miss(34'h100); issue_miss(34'h200);
    step(); miss_valid = 0;
    wait_idle(1);
    chk("t2_req_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t2_first_id", grant_log[0], 0);
      chk("t2_second_id", grant_log[1], 1);
    end

    // Randomized traffic.
    repeat (2500) begin
      step();
      if (!(miss_valid && miss_retry_seen)) begin
        miss_valid = ($urandom_range(0, 1) == 1);
        miss_laddr = pool[$urandom_range(0, 5)];
      end
      l2req_retry = ($urandom_range(0, 3) == 0);
      fill_retry  = ($urandom_range(0, 2) == 0);
    end
    miss_valid = 0; l2req_retry = 0; fill_retry = 0;
    wait_idle(0);

    // Reset while two lines are awaiting fills.
    hold_snack = 1;
    issue_miss(34'h400); issue_miss(34'h500);
    step(); miss_valid = 0;
    repeat (4) step();
    chk("t6_busy_before", busy, 1);
    @(posedge clk); #3;
    reset = 1;
    #1;
    chk("t6_l2req_valid", l2req_valid, 0);
    chk("t6_fill_valid", fill_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_miss_retry", miss_retry, 0);
    chk("t6_snack_retry", snack_retry, 0);
    repeat (2) step();
    reset = 0; hold_snack = 0;
    miss_valid = 1; miss_laddr = 34'h600;
    step(); miss_valid = 0;
    chk("t6_new_valid", l2req_valid, 1);
    chk("t6_new_id", l2req_id, 0);
    chk("t6_new_laddr", l2req_laddr, 34'h600);
    wait_idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
